// File: rtl/hamming_pkg.sv
// Shared Hamming helpers: parity-width derivation, position/index mapping and
// width-generic encode/syndrome/extract functions sized for up to 64 data bits.
package hamming_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_PAR_W  = 7;
    localparam int MAX_HAM_W  = MAX_DATA_W + MAX_PAR_W;
    localparam int MAX_CODE_W = MAX_HAM_W + 1;
    localparam int SYN_W      = 8;

    function automatic int par_w(input int data_w);
        int r;
        r = 1;
        while ((2 ** r) < (data_w + r + 1)) r++;
        return r;
    endfunction

    // Hamming positions are 1-based; powers of two hold parity, the rest hold data.
    function automatic logic is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    function automatic logic [MAX_CODE_W-1:0] enc_f(input logic [MAX_DATA_W-1:0] data,
                                                    input int data_w,
                                                    input int secded);
        logic [MAX_CODE_W-1:0] code;
        int ham_w;
        int di;
        ham_w = data_w + par_w(data_w);
        code  = '0;
        di    = 0;
        for (int p = 1; p <= MAX_HAM_W; p++) begin
            if (p <= ham_w && !is_pow2(p)) begin
                code[p-1] = data[di];
                di++;
            end
        end
        for (int k = 0; k < MAX_PAR_W; k++) begin
            for (int p = 1; p <= MAX_HAM_W; p++) begin
                if (p <= ham_w && p[k] && !is_pow2(p)) code[(1 << k) - 1] ^= code[p-1];
            end
        end
        if (secded != 0) code[ham_w] = ^code;
        return code;
    endfunction

    function automatic logic [SYN_W-1:0] syn_f(input logic [MAX_CODE_W-1:0] code,
                                               input int ham_w);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int p = 1; p <= MAX_HAM_W; p++) begin
            if (p <= ham_w && code[p-1]) s ^= SYN_W'(p);
        end
        return s;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] ext_f(input logic [MAX_CODE_W-1:0] code,
                                                    input int data_w);
        logic [MAX_DATA_W-1:0] data;
        int ham_w;
        int di;
        ham_w = data_w + par_w(data_w);
        data  = '0;
        di    = 0;
        for (int p = 1; p <= MAX_HAM_W; p++) begin
            if (p <= ham_w && !is_pow2(p)) begin
                data[di] = code[p-1];
                di++;
            end
        end
        return data;
    endfunction

endpackage

// File: rtl/hamming_pipe_reg.sv
// One-deep valid/ready output register; accepts a new word whenever it is empty
// or its current word is being taken downstream in the same cycle.
module hamming_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [W-1:0] s_data_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign s_ready_o = !valid_q || m_ready_i;
    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (s_ready_o) begin
            valid_d = s_valid_i;
            if (s_valid_i) data_d = s_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/hamming_secded_codec.sv
// Streaming Hamming SEC / SEC-DED encoder or decoder (selected by DECODE) with a
// single registered output stage and saturating error counters in decode mode.
module hamming_secded_codec
    import hamming_pkg::*;
#(
    parameter int  DATA_W = 4,
    parameter int  SECDED = 1,
    parameter int  DECODE = 0,
    parameter int  CNT_W  = 8,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int HAM_W  = DATA_W + PAR_W,
    localparam int CODE_W = HAM_W + SECDED,
    localparam int IN_W   = (DECODE != 0) ? CODE_W : DATA_W,
    localparam int OUT_W  = (DECODE != 0) ? DATA_W : CODE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_err_corr,
    output logic             m_err_dbl,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_dbl,
    input  logic             cnt_clr
);

    logic [OUT_W-1:0] res_data;
    logic             res_corr;
    logic             res_dbl;
    logic             accept;

    if (DECODE != 0) begin : g_dec
        localparam logic [SYN_W-1:0] HAM_W_S = SYN_W'(HAM_W);
        logic [CODE_W-1:0] code;
        logic [CODE_W-1:0] fixed;
        logic [SYN_W-1:0]  syn;
        logic              par;

        // Syndrome points at the bad position; overall parity separates single from double errors.
        always_comb begin
            code     = s_data;
            syn      = syn_f(MAX_CODE_W'(code), HAM_W);
            par      = (SECDED != 0) ? ^code : 1'b0;
            fixed    = code;
            res_corr = 1'b0;
            res_dbl  = 1'b0;
            if (SECDED != 0) begin
                if (par) begin
                    if (syn == '0) begin
                        res_corr = 1'b1;
                    end else if (syn <= HAM_W_S) begin
                        fixed    = code ^ (CODE_W'(1) << (syn - SYN_W'(1)));
                        res_corr = 1'b1;
                    end else begin
                        res_dbl = 1'b1;
                    end
                end else if (syn != '0) begin
                    res_dbl = 1'b1;
                end
            end else if (syn != '0) begin
                if (syn <= HAM_W_S) begin
                    fixed    = code ^ (CODE_W'(1) << (syn - SYN_W'(1)));
                    res_corr = 1'b1;
                end else begin
                    res_dbl = 1'b1;
                end
            end
            res_data = DATA_W'(ext_f(MAX_CODE_W'(fixed), DATA_W));
        end
    end else begin : g_enc
        always_comb begin
            res_data = CODE_W'(enc_f(MAX_DATA_W'(s_data), DATA_W, SECDED));
            res_corr = 1'b0;
            res_dbl  = 1'b0;
        end
    end

    hamming_pipe_reg #(
        .W (OUT_W + 2)
    ) u_pipe (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  ({res_corr, res_dbl, res_data}),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  ({m_err_corr, m_err_dbl, m_data})
    );

    assign accept = s_valid && s_ready;

    logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0] cnt_dbl_q, cnt_dbl_d;

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        cnt_corr_d = cnt_corr_q;
        cnt_dbl_d  = cnt_dbl_q;
        if (cnt_clr) begin
            cnt_corr_d = '0;
            cnt_dbl_d  = '0;
        end else begin
            if (accept && res_corr && (cnt_corr_q != '1)) cnt_corr_d = cnt_corr_q + CNT_W'(1);
            if (accept && res_dbl && (cnt_dbl_q != '1))   cnt_dbl_d  = cnt_dbl_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr_q <= '0;
            cnt_dbl_q  <= '0;
        end else begin
            cnt_corr_q <= cnt_corr_d;
            cnt_dbl_q  <= cnt_dbl_d;
        end
    end

    assign cnt_corr = cnt_corr_q;
    assign cnt_dbl  = cnt_dbl_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed bench: 4-bit encoder/decoder vectors, stall, saturation and async reset,
// plus an encode-flip-decode chain at 11/26/57 data bits.
module tb_hamming_secded_codec;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // 4-bit encoder
    logic       eValid = 1'b0, eReady, emValid, emReady = 1'b1, eCorr, eDbl;
    logic [3:0] eData = '0;
    logic [7:0] emData, eCntCorr, eCntDbl;

    hamming_secded_codec #(.DATA_W(4), .SECDED(1), .DECODE(0), .CNT_W(8)) uEnc (
        .clk(clk), .rst_n(rst_n), .s_valid(eValid), .s_ready(eReady), .s_data(eData),
        .m_valid(emValid), .m_ready(emReady), .m_data(emData), .m_err_corr(eCorr),
        .m_err_dbl(eDbl), .cnt_corr(eCntCorr), .cnt_dbl(eCntDbl), .cnt_clr(1'b0)
    );

    // 4-bit decoder with 2-bit counters
    logic       dValid = 1'b0, dReady, dmValid, dmReady = 1'b1, dCorr, dDbl, dClr = 1'b0;
    logic [7:0] dData = '0;
    logic [3:0] dmData;
    logic [1:0] dCntCorr, dCntDbl;

    hamming_secded_codec #(.DATA_W(4), .SECDED(1), .DECODE(1), .CNT_W(2)) uDec (
        .clk(clk), .rst_n(rst_n), .s_valid(dValid), .s_ready(dReady), .s_data(dData),
        .m_valid(dmValid), .m_ready(dmReady), .m_data(dmData), .m_err_corr(dCorr),
        .m_err_dbl(dDbl), .cnt_corr(dCntCorr), .cnt_dbl(dCntDbl), .cnt_clr(dClr)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] enc4Model(input logic [3:0] d);
        logic [7:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = ^c[6:0];
        return c;
    endfunction

    // One word through encoder (isDec=0) or decoder (isDec=1); outputs valid on return.
    task automatic applyStimulus(input logic isDec, input logic [7:0] word);
        @(negedge clk);
        if (isDec) begin
            dValid = 1'b1;
            dData  = word;
        end else begin
            eValid = 1'b1;
            eData  = word[3:0];
        end
        @(posedge clk);
        #1;
        dValid = 1'b0;
        eValid = 1'b0;
    endtask

    // Encode -> single flip -> decode chains at larger widths
    localparam int SW_DATA[3] = '{11, 26, 57};
    localparam int SW_CODE[3] = '{16, 32, 64};

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W  = SW_DATA[g];
        localparam int CW = SW_CODE[g];
        logic          inV = 1'b0, inR, midV, midR, outV;
        logic [W-1:0]  inD = '0, outD;
        logic [CW-1:0] midD, flip = '0;
        logic          eC, eD, dC, dD;
        logic [7:0]    eCc, eCd, dCc, dCd;

        hamming_secded_codec #(.DATA_W(W), .SECDED(1), .DECODE(0)) uSwEnc (
            .clk(clk), .rst_n(rst_n), .s_valid(inV), .s_ready(inR), .s_data(inD),
            .m_valid(midV), .m_ready(midR), .m_data(midD), .m_err_corr(eC), .m_err_dbl(eD),
            .cnt_corr(eCc), .cnt_dbl(eCd), .cnt_clr(1'b0)
        );
        hamming_secded_codec #(.DATA_W(W), .SECDED(1), .DECODE(1)) uSwDec (
            .clk(clk), .rst_n(rst_n), .s_valid(midV), .s_ready(midR), .s_data(midD ^ flip),
            .m_valid(outV), .m_ready(1'b1), .m_data(outD), .m_err_corr(dC), .m_err_dbl(dD),
            .cnt_corr(dCc), .cnt_dbl(dCd), .cnt_clr(1'b0)
        );

        task automatic runSweep();
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                inD  = W'({$urandom, $urandom});
                flip = (n == 0) ? '0 : (CW'(1) << $urandom_range(CW - 1, 0));
                inV  = 1'b1;
                @(negedge clk);
                inV = 1'b0;
                @(negedge clk);
                checkOutput($sformatf("sweep%0d valid", W), 64'(outV), 64'(1));
                checkOutput($sformatf("sweep%0d data", W), 64'(outD), 64'(inD));
                checkOutput($sformatf("sweep%0d corr", W), 64'(dC), 64'(flip != '0));
                checkOutput($sformatf("sweep%0d dbl", W), 64'(dD), 64'(0));
            end
            checkOutput($sformatf("sweep%0d cnt_corr", W), 64'(dCc), 64'(11));
        endtask
    end

    typedef struct {
        logic [3:0] data;
        logic [7:0] code;
    } encVec_t;

    typedef struct {
        logic [7:0] code;
        logic [3:0] data;
        logic       corr;
        logic       dbl;
    } decVec_t;

    encVec_t encTab[6];
    decVec_t decTab[9];

    initial begin
        logic [3:0] words[6];
        logic [7:0] held;
        int         idx, got;
        logic       stallSeen;

        encTab = '{'{4'h0, 8'h00}, '{4'h1, 8'h87}, '{4'h2, 8'h99},
                   '{4'h8, 8'h4B}, '{4'hB, 8'h55}, '{4'hF, 8'hFF}};
        decTab = '{'{8'h55, 4'hB, 1'b0, 1'b0}, '{8'h45, 4'hB, 1'b1, 1'b0},
                   '{8'h56, 4'hB, 1'b0, 1'b1}, '{8'hD5, 4'hB, 1'b1, 1'b0},
                   '{8'h87, 4'h1, 1'b0, 1'b0}, '{8'h86, 4'h1, 1'b1, 1'b0},
                   '{8'h7F, 4'hF, 1'b1, 1'b0}, '{8'hE7, 4'hD, 1'b0, 1'b1},
                   '{8'h00, 4'h0, 1'b0, 1'b0}};

        #12;
        checkOutput("rst enc m_valid", 64'(emValid), 64'(0));
        checkOutput("rst enc m_data", 64'(emData), 64'(0));
        checkOutput("rst dec m_valid", 64'(dmValid), 64'(0));
        checkOutput("rst dec m_data", 64'(dmData), 64'(0));
        checkOutput("rst dec flags", 64'({dCorr, dDbl}), 64'(0));
        checkOutput("rst dec counters", 64'({dCntCorr, dCntDbl}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Encoder: 4'hB, then hand vectors, then all inputs against the bit-level model
        applyStimulus(1'b0, 8'h0B);
        checkOutput("enc B valid", 64'(emValid), 64'(1));
        checkOutput("enc B code", 64'(emData), 64'h55);
        @(posedge clk);
        #1;
        checkOutput("enc valid drop", 64'(emValid), 64'(0));
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, {4'h0, encTab[i].data});
            checkOutput($sformatf("enc table %0h", encTab[i].data), 64'(emData), 64'(encTab[i].code));
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'(i));
            checkOutput($sformatf("enc model %0h", i), 64'(emData), 64'(enc4Model(4'(i))));
            checkOutput("enc flags", 64'({eCorr, eDbl}), 64'(0));
        end

        // Decoder single and double error with counters
        applyStimulus(1'b1, 8'h45);
        checkOutput("dec 45 data", 64'(dmData), 64'hB);
        checkOutput("dec 45 corr", 64'(dCorr), 64'(1));
        checkOutput("dec 45 cnt_corr", 64'(dCntCorr), 64'(1));
        applyStimulus(1'b1, 8'h56);
        checkOutput("dec 56 dbl", 64'(dDbl), 64'(1));
        checkOutput("dec 56 corr", 64'(dCorr), 64'(0));
        checkOutput("dec 56 cnt_dbl", 64'(dCntDbl), 64'(1));
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, decTab[i].code);
            checkOutput($sformatf("dec table %0h data", decTab[i].code), 64'(dmData), 64'(decTab[i].data));
            checkOutput($sformatf("dec table %0h flags", decTab[i].code), 64'({dCorr, dDbl}),
                        64'({decTab[i].corr, decTab[i].dbl}));
        end

        // Back-to-back stream with a 3-cycle downstream stall
        words = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h0, 4'hF};
        idx = 0;
        got = 0;
        stallSeen = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            emReady = !(cyc >= 2 && cyc < 5);
            eValid  = (idx < 6);
            eData   = words[idx < 6 ? idx : 5];
            #1;
            if (emValid && !emReady) begin
                checkOutput("stall s_ready", 64'(eReady), 64'(0));
                if (stallSeen) checkOutput("stall data held", 64'(emData), 64'(held));
                held = emData;
                stallSeen = 1'b1;
            end
            if (emValid && emReady) begin
                checkOutput($sformatf("stream word %0d", got), 64'(emData), 64'(enc4Model(words[got])));
                got++;
            end
            if (eValid && eReady) idx++;
        end
        @(negedge clk);
        eValid = 1'b0;
        emReady = 1'b1;
        checkOutput("stream count", 64'(got), 64'(6));
        checkOutput("stall observed", 64'(stallSeen), 64'(1));

        // Counter saturation and clear-vs-increment priority
        @(negedge clk);
        dClr = 1'b1;
        @(negedge clk);
        dClr = 1'b0;
        checkOutput("clr cnt_corr", 64'(dCntCorr), 64'(0));
        checkOutput("clr cnt_dbl", 64'(dCntDbl), 64'(0));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h45);
            checkOutput($sformatf("sat cnt_corr %0d", i), 64'(dCntCorr), 64'(i < 3 ? i + 1 : 3));
        end
        @(negedge clk);
        dClr = 1'b1;
        dValid = 1'b1;
        dData = 8'h45;
        @(posedge clk);
        #1;
        dClr = 1'b0;
        dValid = 1'b0;
        checkOutput("clr wins cnt_corr", 64'(dCntCorr), 64'(0));
        checkOutput("clr wins word corr", 64'(dCorr), 64'(1));

        // Asynchronous reset while a word is held
        @(negedge clk);
        @(negedge clk);
        dmReady = 1'b0;
        applyStimulus(1'b1, 8'h45);
        @(negedge clk);
        checkOutput("held before rst", 64'(dmValid), 64'(1));
        checkOutput("cnt before rst", 64'(dCntCorr), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst m_valid", 64'(dmValid), 64'(0));
        checkOutput("async rst m_data", 64'(dmData), 64'(0));
        checkOutput("async rst flags", 64'({dCorr, dDbl}), 64'(0));
        checkOutput("async rst cnt", 64'({dCntCorr, dCntDbl}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dmReady = 1'b1;
        @(negedge clk);
        checkOutput("no output after rst", 64'(dmValid), 64'(0));

        g_sweep[0].runSweep();
        g_sweep[1].runSweep();
        g_sweep[2].runSweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
